serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer. Computes a WIDTH-bit sum by time-sharing one external 1-bit full adder, LSB first, one bit per clock.
- Sits between a requester (start/done handshake) and a single full-adder datapath instance. Drives the adder's three inputs and captures its two outputs.
- Because it never instantiates the adder itself, a normal cell or a trojan-infected cell can be placed behind it unchanged for comparison runs.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/serial_add_ctrl.sv | 87 ++++++++
 tb/tb_serial_add_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first,
// one bit per clock, and reports the registered WIDTH-bit result with done.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  assign fa_a   = a_sr[0];
  assign fa_b   = b_sr[0];
  assign fa_cin = carry;

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            // On the MSB cycle 'carry' is the carry into the MSB, so the
            // overflow term is formed here directly instead of being stored.
            sum   <= {fa_sum, res_sr[WIDTH-1:1]};
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a normal or trojan-infected full adder.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic         infected;

  int passed = 0;
  int total  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  // Full adder built from two half adders; the infected variant forces the
  // first half adder's carry high when both of its inputs are 0.
  logic s1, c1;
  always_comb begin
    s1 = fa_a ^ fa_b;
    c1 = fa_a & fa_b;
    if (infected && !fa_a && !fa_b) c1 = 1'b1;
    fa_sum  = s1 ^ fa_cin;
    fa_cout = c1 | (s1 & fa_cin);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches one operation and returns the cycle (1 = first after accept) of done.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, output int done_cycle);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    done_cycle = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        done_cycle = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; infected = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_add();
    int dc;
    do_op(8'h3C, 8'h5A, 1'b0, dc);
    total++; if (dc !== 9) $display("FAIL add1_latency: got %0d want 9", dc); else passed++;
    total++; if (sum !== 8'h96) $display("FAIL add1_sum: got %h want 96", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL add1_cout: got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL add1_ovf: got %b want 1", ovf); else passed++;
    do_op(8'hFF, 8'h01, 1'b0, dc);
    total++; if (sum !== 8'h00) $display("FAIL add2_sum: got %h want 00", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL add2_cout: got %b want 1", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL add2_ovf: got %b want 0", ovf); else passed++;
    do_op(8'hFF, 8'hFF, 1'b1, dc);
    total++; if (sum !== 8'hFF) $display("FAIL add3_sum: got %h want ff", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL add3_cout: got %b want 1", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL add3_ovf: got %b want 0", ovf); else passed++;
    // Held outputs must not move once done has dropped.
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done); else passed++;
    total++; if (sum !== 8'hFF) $display("FAIL sum_hold: got %h want ff", sum); else passed++;
  endtask

  task automatic test_infected();
    int dc;
    infected = 1'b1;
    do_op(8'h00, 8'h00, 1'b0, dc);
    total++; if (sum !== 8'hFE) $display("FAIL inf_sum: got %h want fe", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL inf_cout: got %b want 1", cout); else passed++;
    infected = 1'b0;
    do_op(8'h00, 8'h00, 1'b0, dc);
    total++; if (sum !== 8'h00) $display("FAIL norm0_sum: got %h want 00", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL norm0_cout: got %b want 0", cout); else passed++;
  endtask

  task automatic test_start_ignored();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (busy !== (k <= 9)) $display("FAIL ign_busy_c%0d: got %b want %b", k, busy, (k <= 9));
      else passed++;
      if (done) ndone++;
      if (k == 3 || k == 8) begin
        a = 8'hAA; b = 8'hAA; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d want 1", ndone); else passed++;
    total++; if (sum !== 8'h33) $display("FAIL ign_sum: got %h want 33", sum); else passed++;
  endtask

  task automatic test_reset_mid();
    int ndone;
    int dc;
    ndone = 0;
    @(negedge clk);
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else passed++;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    total++; if (sum !== 8'h00) $display("FAIL mid_sum: got %h want 00", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL mid_cout: got %b want 0", cout); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL mid_no_done: got %0d want 0", ndone); else passed++;
    do_op(8'h01, 8'h01, 1'b0, dc);
    total++; if (sum !== 8'h02) $display("FAIL mid_fresh_sum: got %h want 02", sum); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_sum [3];
    logic         exp_cout [3];
    int           exp_cyc [3];
    int           idx;
    exp_sum[0] = 8'h03; exp_cout[0] = 1'b0; exp_cyc[0] = 9;
    exp_sum[1] = 8'h1E; exp_cout[1] = 1'b0; exp_cyc[1] = 19;
    exp_sum[2] = 8'h00; exp_cout[2] = 1'b1; exp_cyc[2] = 29;
    idx = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k <= 30) begin
        total++;
        if (busy !== !(k == 10 || k == 20 || k == 30))
          $display("FAIL b2b_busy_c%0d: got %b want %b", k, busy, !(k == 10 || k == 20 || k == 30));
        else passed++;
      end
      if (done) begin
        total++;
        if (idx > 2) $display("FAIL b2b_extra_done: got done at cycle %0d want none", k);
        else if (k !== exp_cyc[idx] || sum !== exp_sum[idx] || cout !== exp_cout[idx])
          $display("FAIL b2b_run%0d: got cyc %0d sum %h cout %b want cyc %0d sum %h cout %b",
                   idx, k, sum, cout, exp_cyc[idx], exp_sum[idx], exp_cout[idx]);
        else passed++;
        idx++;
      end
      if (k == 5)  begin a = 8'h0A; b = 8'h14; end
      if (k == 15) begin a = 8'h80; b = 8'h80; end
      if (k == 25) start = 1'b0;
    end
    total++; if (idx !== 3) $display("FAIL b2b_done_count: got %0d want 3", idx); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_infected();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
